// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch next-PC generator and its BTB.
package fetch_pkg;

  localparam int unsigned PC_W        = 15;
  localparam int unsigned BTB_IDX_W   = 6;
  localparam int unsigned TAG_W       = PC_W - BTB_IDX_W;
  localparam int unsigned BTB_ENTRIES = 1 << BTB_IDX_W;

  typedef logic [PC_W-1:0] pc_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    pc_t              target;
  } btb_entry_t;

  // Direct-mapped BTB index: low PC bits
  function automatic logic [BTB_IDX_W-1:0] pc_idx(input pc_t pc);
    return pc[BTB_IDX_W-1:0];
  endfunction

  // BTB tag: PC bits above the index
  function automatic logic [TAG_W-1:0] pc_tag(input pc_t pc);
    return pc[PC_W-1:BTB_IDX_W];
  endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: registered read port, single write port,
// valid bits cleared in one cycle by rst. A read and write to the same
// index in the same cycle returns the pre-write contents.
module btb_array
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [BTB_IDX_W-1:0] rd_idx,
  output btb_entry_t           rd_entry,
  input  logic                 wr_en,
  input  logic [BTB_IDX_W-1:0] wr_idx,
  input  btb_entry_t           wr_entry
);

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
  pc_t                    tgt_mem [BTB_ENTRIES];
  btb_entry_t             rd_q, rd_d;

  // Valid-bit update and read capture; reads see the current (old) arrays
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    if (wr_en) valid_d[wr_idx] = wr_entry.valid;
    if (rd_en) rd_d = {valid_q[rd_idx], tag_mem[rd_idx], tgt_mem[rd_idx]};
  end

  // Valid bits and read register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end

  // Tag/target payload; no reset needed since valid gates every hit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_entry.tag;
      tgt_mem[wr_idx] <= wr_entry.target;
    end
  end

  assign rd_entry = rd_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator with a direct-mapped BTB.
// Optional feature macro: FETCH_PERF_CNT_EN (adds br_count / mispred_count).
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            predict,
  output logic [PC_W-1:0] PCF,
  output logic [PC_W-1:0] PCD,
  output logic            pred_taken_d,
  output logic [PC_W-1:0] pred_tgt_d,
  input  logic            ex_valid,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_tgt,
  output logic            bp_update_en,
  output logic            FlushD,
  output logic            FlushE
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
`endif
);

  pc_t        pcf_q, pcf_d;
  pc_t        pcd_q, pcd_d;
  logic       d_valid_q, d_valid_d;
  btb_entry_t rd_entry;
  btb_entry_t wr_entry;
  logic       btb_hit_d;
  logic       mis_e;
  logic       redirect_d;

  assign wr_entry = '{valid: 1'b1, tag: pc_tag(ex_pc), target: ex_target};

  btb_array u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (~StallD),
    .rd_idx   (pc_idx(pcf_q)),
    .rd_entry (rd_entry),
    .wr_en    (ex_valid & ex_taken),
    .wr_idx   (pc_idx(ex_pc)),
    .wr_entry (wr_entry)
  );

  // D-stage prediction; a flushed D slot never predicts taken
  assign btb_hit_d    = d_valid_q & rd_entry.valid & (rd_entry.tag == pc_tag(pcd_q));
  assign pred_taken_d = predict & btb_hit_d;
  assign pred_tgt_d   = rd_entry.target;

  // E-stage direction or target mispredict
  assign mis_e = ex_valid & ((ex_taken != ex_pred_taken) |
                             (ex_taken & (ex_pred_tgt != ex_target)));

  assign redirect_d   = pred_taken_d & ~StallD;
  assign FlushE       = ~rst & mis_e;
  assign FlushD       = ~rst & (mis_e | redirect_d);
  assign bp_update_en = ex_valid;

  // Next-PC priority mux and D-stage capture
  always_comb begin
    pcf_d     = pcf_q + PC_W'(1);
    pcd_d     = pcd_q;
    d_valid_d = d_valid_q;
    if (mis_e) begin
      pcf_d = ex_taken ? ex_target : (ex_pc + PC_W'(1));
    end else if (redirect_d) begin
      pcf_d = pred_tgt_d;
    end else if (StallF) begin
      pcf_d = pcf_q;
    end
    if (FlushD) begin
      d_valid_d = 1'b0;
    end else if (!StallD) begin
      pcd_d     = pcf_q;
      d_valid_d = 1'b1;
    end
  end

  // PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q     <= RESET_PC;
      pcd_q     <= '0;
      d_valid_q <= 1'b0;
    end else begin
      pcf_q     <= pcf_d;
      pcd_q     <= pcd_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign PCF = pcf_q;
  assign PCD = pcd_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Saturating branch / mispredict counters
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (ex_valid && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 32'd1;
    if (mis_e && (mis_cnt_q != '1))   mis_cnt_d = mis_cnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scenario bench for fetch_pc_gen: expected PCF values are queued when
// stimulus is driven and popped after the following rising edge.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, predict;
  logic [14:0] PCF, PCD, pred_tgt_d;
  logic        pred_taken_d, bp_update_en, FlushD, FlushE;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [14:0] ex_pc, ex_target, ex_pred_tgt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] br_count, mispred_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .StallD        (StallD),
    .predict       (predict),
    .PCF           (PCF),
    .PCD           (PCD),
    .pred_taken_d  (pred_taken_d),
    .pred_tgt_d    (pred_tgt_d),
    .ex_valid      (ex_valid),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_tgt   (ex_pred_tgt),
    .bp_update_en  (bp_update_en),
    .FlushD        (FlushD),
    .FlushE        (FlushE)
`ifdef FETCH_PERF_CNT_EN
    ,
    .br_count      (br_count),
    .mispred_count (mispred_count)
`endif
  );

  // Advance one edge and hand back the next expected PCF
  task automatic tick(output logic [14:0] e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty no expected PCF queued");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_taken = 1'b0; ex_pc = '0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_tgt = '0;
  endtask

  // Redirect fetch to t with a not-taken mispredict at t-1 (no BTB write)
  task automatic goto_pc(input logic [14:0] t);
    logic [14:0] e;
    ex_valid = 1'b1; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    ex_pc = t - 15'd1; ex_target = '0; ex_pred_tgt = '0;
    exp_q.push_back(t);
    tick(e);
    clear_ex();
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL goto_pcf got=%h exp=%h", PCF, e); end
  endtask

  task automatic test_reset();
    logic [14:0] e;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; predict = 1'b0;
    clear_ex();
    exp_q.push_back(15'h0000);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL reset_pcf got=%h exp=%h", PCF, e); end
    checks++;
    if (PCD !== 15'h0000) begin failures++; $display("FAIL reset_pcd got=%h exp=0000", PCD); end
    checks++;
    if ({pred_taken_d, FlushD, FlushE} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {pred_taken_d, FlushD, FlushE});
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [14:0] e;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(15'(i));
      tick(e);
      checks++;
      if (PCF !== e) begin failures++; $display("FAIL seq_pcf got=%h exp=%h", PCF, e); end
      checks++;
      if (PCD !== 15'(i - 1)) begin failures++; $display("FAIL seq_pcd got=%h exp=%h", PCD, 15'(i - 1)); end
      checks++;
      if ({FlushD, FlushE} !== 2'b00) begin failures++; $display("FAIL seq_flush got=%b exp=00", {FlushD, FlushE}); end
    end
  endtask

  task automatic test_mispredict_taken();
    logic [14:0] e;
    ex_valid = 1'b1; ex_pc = 15'h010; ex_taken = 1'b1; ex_target = 15'h040;
    ex_pred_taken = 1'b0; ex_pred_tgt = '0;
    #1;
    checks++;
    if ({FlushD, FlushE, bp_update_en} !== 3'b111) begin
      failures++; $display("FAIL mis_taken_flush got=%b exp=111", {FlushD, FlushE, bp_update_en});
    end
    exp_q.push_back(15'h040);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL mis_taken_pcf got=%h exp=%h", PCF, e); end
    clear_ex();
    #1;
    checks++;
    if ({FlushD, bp_update_en} !== 2'b00) begin
      failures++; $display("FAIL mis_taken_after got=%b exp=00", {FlushD, bp_update_en});
    end
  endtask

  task automatic test_btb_predict();
    logic [14:0] e;
    goto_pc(15'h010);
    exp_q.push_back(15'h011);
    tick(e);
    checks++;
    if (PCF !== e || PCD !== 15'h010) begin
      failures++; $display("FAIL pred_setup got=%h/%h exp=%h/010", PCF, PCD, e);
    end
    predict = 1'b1;
    #1;
    checks++;
    if ({pred_taken_d, FlushD, FlushE} !== 3'b110 || pred_tgt_d !== 15'h040) begin
      failures++; $display("FAIL pred_hit got=%b tgt=%h exp=110 tgt=040", {pred_taken_d, FlushD, FlushE}, pred_tgt_d);
    end
    exp_q.push_back(15'h040);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL pred_redirect_pcf got=%h exp=%h", PCF, e); end
    checks++;
    if (pred_taken_d !== 1'b0 || PCD !== 15'h010) begin
      failures++; $display("FAIL pred_flushed_d got=%b/%h exp=0/010", pred_taken_d, PCD);
    end
    predict = 1'b0;
  endtask

  task automatic test_mispredict_not_taken();
    logic [14:0] e;
    ex_valid = 1'b1; ex_pc = 15'h010; ex_taken = 1'b0; ex_target = 15'h040;
    ex_pred_taken = 1'b1; ex_pred_tgt = 15'h040;
    #1;
    checks++;
    if ({FlushD, FlushE} !== 2'b11) begin failures++; $display("FAIL mis_nt_flush got=%b exp=11", {FlushD, FlushE}); end
    exp_q.push_back(15'h011);
    tick(e);
    clear_ex();
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL mis_nt_pcf got=%h exp=%h", PCF, e); end
    goto_pc(15'h010);
    exp_q.push_back(15'h011);
    tick(e);
    predict = 1'b1;
    #1;
    checks++;
    if (pred_taken_d !== 1'b1) begin failures++; $display("FAIL mis_nt_keeps_entry got=%b exp=1", pred_taken_d); end
    predict = 1'b0;
    #1;
    exp_q.push_back(15'h012);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL mis_nt_seq got=%h exp=%h", PCF, e); end
  endtask

  task automatic test_target_mismatch();
    logic [14:0] e;
    ex_valid = 1'b1; ex_pc = 15'h010; ex_taken = 1'b1; ex_target = 15'h060;
    ex_pred_taken = 1'b1; ex_pred_tgt = 15'h040;
    #1;
    checks++;
    if ({FlushD, FlushE} !== 2'b11) begin failures++; $display("FAIL tgt_mis_flush got=%b exp=11", {FlushD, FlushE}); end
    exp_q.push_back(15'h060);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL tgt_mis_pcf got=%h exp=%h", PCF, e); end
    ex_pred_tgt = 15'h060;
    #1;
    checks++;
    if ({FlushD, FlushE, bp_update_en} !== 3'b001) begin
      failures++; $display("FAIL correct_pred got=%b exp=001", {FlushD, FlushE, bp_update_en});
    end
    exp_q.push_back(15'h061);
    tick(e);
    clear_ex();
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL correct_pred_pcf got=%h exp=%h", PCF, e); end
    goto_pc(15'h010);
    exp_q.push_back(15'h011);
    tick(e);
    predict = 1'b1;
    #1;
    checks++;
    if (pred_taken_d !== 1'b1 || pred_tgt_d !== 15'h060) begin
      failures++; $display("FAIL tgt_updated got=%b/%h exp=1/060", pred_taken_d, pred_tgt_d);
    end
    exp_q.push_back(15'h060);
    tick(e);
    predict = 1'b0;
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL tgt_updated_pcf got=%h exp=%h", PCF, e); end
  endtask

  task automatic test_alias();
    logic [14:0] e;
    goto_pc(15'h050);
    exp_q.push_back(15'h051);
    tick(e);
    predict = 1'b1;
    #1;
    checks++;
    if ({pred_taken_d, FlushD} !== 2'b00 || PCD !== 15'h050) begin
      failures++; $display("FAIL alias_hit got=%b pcd=%h exp=00 pcd=050", {pred_taken_d, FlushD}, PCD);
    end
    exp_q.push_back(15'h052);
    tick(e);
    predict = 1'b0;
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL alias_pcf got=%h exp=%h", PCF, e); end
  endtask

  task automatic test_rw_same_index();
    logic [14:0] e;
    goto_pc(15'h020);
    ex_valid = 1'b1; ex_pc = 15'h020; ex_taken = 1'b1; ex_target = 15'h100;
    ex_pred_taken = 1'b1; ex_pred_tgt = 15'h100;
    #1;
    checks++;
    if (FlushD !== 1'b0) begin failures++; $display("FAIL rw_flush got=%b exp=0", FlushD); end
    exp_q.push_back(15'h021);
    tick(e);
    clear_ex();
    predict = 1'b1;
    #1;
    checks++;
    if (PCF !== e || pred_taken_d !== 1'b0) begin
      failures++; $display("FAIL rw_old_data got=%h/%b exp=%h/0", PCF, pred_taken_d, e);
    end
    predict = 1'b0;
    goto_pc(15'h020);
    exp_q.push_back(15'h021);
    tick(e);
    predict = 1'b1;
    #1;
    checks++;
    if (pred_taken_d !== 1'b1 || pred_tgt_d !== 15'h100) begin
      failures++; $display("FAIL rw_new_data got=%b/%h exp=1/100", pred_taken_d, pred_tgt_d);
    end
    predict = 1'b0;
  endtask

  task automatic test_stall_and_wrap();
    logic [14:0] e;
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(15'h021);
      tick(e);
      checks++;
      if (PCF !== e || PCD !== 15'h020) begin
        failures++; $display("FAIL stall_hold got=%h/%h exp=%h/020", PCF, PCD, e);
      end
    end
    ex_valid = 1'b1; ex_pc = 15'h7FFE; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    #1;
    checks++;
    if ({FlushD, FlushE} !== 2'b11) begin failures++; $display("FAIL stall_mis_flush got=%b exp=11", {FlushD, FlushE}); end
    exp_q.push_back(15'h7FFF);
    tick(e);
    clear_ex();
    StallF = 1'b0; StallD = 1'b0;
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL stall_mis_pcf got=%h exp=%h", PCF, e); end
    exp_q.push_back(15'h0000);
    tick(e);
    checks++;
    if (PCF !== e) begin failures++; $display("FAIL wrap_pcf got=%h exp=%h", PCF, e); end
  endtask

  task automatic test_mid_reset();
    logic [14:0] e;
    rst = 1'b1;
    exp_q.push_back(15'h0000);
    tick(e);
    rst = 1'b0;
    checks++;
    if (PCF !== e || PCD !== 15'h0000) begin
      failures++; $display("FAIL midrst_pc got=%h/%h exp=%h/0000", PCF, PCD, e);
    end
    goto_pc(15'h010);
    exp_q.push_back(15'h011);
    tick(e);
    predict = 1'b1;
    #1;
    checks++;
    if (pred_taken_d !== 1'b0) begin failures++; $display("FAIL midrst_btb_cleared got=%b exp=0", pred_taken_d); end
    predict = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mispredict_taken();
    test_btb_predict();
    test_mispredict_not_taken();
    test_target_mismatch();
    test_alias();
    test_rw_same_index();
    test_stall_and_wrap();
    test_mid_reset();
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
